// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues req/ack fetches and drives IF/ID
// write enable / flush, absorbing memory wait states, load-use stalls and branch redirects.
module fetch_ctrl #(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req,
  output logic [PC_W-1:0]  o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [PC_W-1:0]  i_imem_rdata,
  input  logic             i_ld_use_stall,
  input  logic             i_br_taken,
  input  logic [PC_W-1:0]  i_br_target,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic [PC_W-1:0]  o_pc_out,
  output logic [PC_W-1:0]  o_instr_out,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e            r_state, w_state_d;
  logic [PC_W-1:0]   r_pc, w_pc_d, w_pc4;
  logic [PC_W-1:0]   r_buf_instr, r_buf_pc4;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              w_buf_ld, w_cnt_inc;

  assign w_pc4          = r_pc + PC_W'(4);
  assign o_imem_addr    = r_pc;
  assign o_stall_cycles = r_stall_cycles;

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_buf_ld     = 1'b0;
    o_imem_req   = 1'b0;
    o_ifid_en    = 1'b0;
    o_ifid_flush = 1'b0;
    o_pc_out     = '0;
    o_instr_out  = '0;
    unique case (r_state)
      StBoot: begin
        o_ifid_flush = 1'b1;
        w_state_d    = StFetch;
      end
      StFetch: begin
        o_imem_req  = 1'b1;
        o_instr_out = i_imem_rdata;
        o_pc_out    = w_pc4;
        // Taken branch wins over any ack or stall arriving in the same cycle.
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_d       = i_br_target;
        end else if (i_imem_ack) begin
          w_pc_d = w_pc4;
          if (i_ld_use_stall) begin
            w_buf_ld  = 1'b1;
            w_state_d = StHold;
          end else begin
            o_ifid_en = 1'b1;
          end
        end
      end
      StHold: begin
        o_instr_out = r_buf_instr;
        o_pc_out    = r_buf_pc4;
        if (i_br_taken) begin
          o_ifid_flush = 1'b1;
          w_pc_d       = i_br_target;
          w_state_d    = StFetch;
        end else if (!i_ld_use_stall) begin
          o_ifid_en = 1'b1;
          w_state_d = StFetch;
        end
      end
      default: w_state_d = StBoot;
    endcase
  end

  assign w_cnt_inc = (r_state != StBoot) && !o_ifid_en && !o_ifid_flush &&
                     (r_stall_cycles != {CNT_W{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StBoot;
      r_pc           <= RESET_PC;
      r_buf_instr    <= '0;
      r_buf_pc4      <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      if (w_buf_ld) begin
        r_buf_instr <= i_imem_rdata;
        r_buf_pc4   <= w_pc4;
      end
      if (w_cnt_inc) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl, plus a hand sequence on a second instance
// with a wrapping reset PC and a narrow saturating stall counter.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, ack, stall, br;
  logic [31:0] rdata, tgt;

  logic        a_req, a_en, a_flush;
  logic [31:0] a_addr, a_pc, a_instr;
  logic [15:0] a_cnt;
  logic        b_req, b_en, b_flush;
  logic [31:0] b_addr, b_pc, b_instr;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut_a (
    .i_clk(clk), .i_rst(rst), .o_imem_req(a_req), .o_imem_addr(a_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata), .i_ld_use_stall(stall),
    .i_br_taken(br), .i_br_target(tgt), .o_ifid_en(a_en), .o_ifid_flush(a_flush),
    .o_pc_out(a_pc), .o_instr_out(a_instr), .o_stall_cycles(a_cnt)
  );

  fetch_ctrl #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .o_imem_req(b_req), .o_imem_addr(b_addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata), .i_ld_use_stall(stall),
    .i_br_taken(br), .i_br_target(tgt), .o_ifid_en(b_en), .o_ifid_flush(b_flush),
    .o_pc_out(b_pc), .o_instr_out(b_instr), .o_stall_cycles(b_cnt)
  );

  typedef struct {
    logic        rst, ack, stall, br;
    logic [31:0] tgt;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        en, flush;
    logic [31:0] pc, instr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a, input logic s, input logic b,
                     input logic [31:0] t, input logic c, input logic req,
                     input logic [31:0] addr, input logic en, input logic fl,
                     input logic [31:0] pc, input logic [31:0] ins, input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.br = b; v.tgt = t; v.chk = c;
    v.req = req; v.addr = addr; v.en = en; v.flush = fl; v.pc = pc; v.instr = ins;
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; rdata = '0; tgt = '0;

    //   rst ack stl br  tgt        chk req addr   en fl pc_out  instr          cnt
    add(1, 0, 0, 0, 0,         0, 0, 0,      0, 1, 0,      0,              0);
    add(1, 0, 0, 0, 0,         1, 0, 0,      0, 1, 0,      0,              0);
    add(0, 1, 0, 0, 0,         1, 0, 0,      0, 1, 0,      0,              0);
    add(0, 1, 0, 0, 0,         1, 1, 0,      1, 0, 4,      32'h0 ^ K,      0);
    add(0, 1, 0, 0, 0,         1, 1, 4,      1, 0, 8,      32'h4 ^ K,      0);
    add(0, 0, 0, 0, 0,         1, 1, 8,      0, 0, 12,     32'h8 ^ K,      0);
    add(0, 0, 0, 0, 0,         1, 1, 8,      0, 0, 12,     32'h8 ^ K,      1);
    add(0, 0, 0, 0, 0,         1, 1, 8,      0, 0, 12,     32'h8 ^ K,      2);
    add(0, 1, 0, 0, 0,         1, 1, 8,      1, 0, 12,     32'h8 ^ K,      3);
    add(0, 1, 0, 0, 0,         1, 1, 12,     1, 0, 16,     32'hC ^ K,      3);
    add(0, 1, 1, 0, 0,         1, 1, 16,     0, 0, 20,     32'h10 ^ K,     3);
    add(0, 0, 1, 0, 0,         1, 0, 20,     0, 0, 20,     32'h10 ^ K,     4);
    add(0, 0, 0, 0, 0,         1, 0, 20,     1, 0, 20,     32'h10 ^ K,     5);
    add(0, 1, 0, 0, 0,         1, 1, 20,     1, 0, 24,     32'h14 ^ K,     5);
    add(0, 1, 1, 0, 0,         1, 1, 24,     0, 0, 28,     32'h18 ^ K,     5);
    add(0, 0, 1, 1, 32'h100,   1, 0, 28,     0, 1, 28,     32'h18 ^ K,     6);
    add(0, 1, 0, 0, 0,         1, 1, 32'h100, 1, 0, 32'h104, 32'h100 ^ K,  6);
    add(0, 0, 0, 1, 32'h203,   1, 1, 32'h104, 0, 1, 32'h108, 32'h104 ^ K,  6);
    add(0, 1, 1, 0, 0,         1, 1, 32'h203, 0, 0, 32'h207, 32'h203 ^ K,  6);
    add(1, 0, 1, 0, 0,         1, 0, 32'h207, 0, 0, 32'h207, 32'h203 ^ K,  7);
    add(0, 0, 0, 0, 0,         1, 0, 0,      0, 1, 0,      0,              0);
    add(0, 0, 0, 0, 0,         1, 1, 0,      0, 0, 4,      32'h0 ^ K,      0);
    add(1, 0, 0, 0, 0,         1, 1, 0,      0, 0, 4,      32'h0 ^ K,      1);
    add(0, 0, 0, 0, 0,         1, 0, 0,      0, 1, 0,      0,              0);
    add(0, 1, 1, 1, 32'h40,    1, 1, 0,      0, 1, 4,      32'h0 ^ K,      0);
    add(0, 1, 0, 0, 0,         1, 1, 32'h40, 1, 0, 32'h44, 32'h40 ^ K,     0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; ack = vecs[i].ack; stall = vecs[i].stall;
      br = vecs[i].br; tgt = vecs[i].tgt; rdata = vecs[i].addr ^ K;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d req", i),   {31'b0, a_req},   {31'b0, vecs[i].req});
        check($sformatf("v%0d addr", i),  a_addr,           vecs[i].addr);
        check($sformatf("v%0d en", i),    {31'b0, a_en},    {31'b0, vecs[i].en});
        check($sformatf("v%0d flush", i), {31'b0, a_flush}, {31'b0, vecs[i].flush});
        check($sformatf("v%0d pc", i),    a_pc,             vecs[i].pc);
        check($sformatf("v%0d instr", i), a_instr,          vecs[i].instr);
        check($sformatf("v%0d cnt", i),   {16'b0, a_cnt},   {16'b0, vecs[i].cnt});
      end
    end

    // Wrapping reset PC and 2-bit saturating counter on the second instance.
    @(negedge clk); rst = 1'b1; ack = 1'b0; stall = 1'b0; br = 1'b0; rdata = '0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFC ^ K; #1;
    check("b boot flush", {31'b0, b_flush}, 32'd1);
    check("b boot req", {31'b0, b_req}, 32'd0);
    @(negedge clk); #1;
    check("b first en", {31'b0, b_en}, 32'd1);
    check("b first pc_out", b_pc, 32'h0);
    check("b first addr", b_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ack = 1'b0; rdata = K; #1;
      check($sformatf("b wait%0d addr", i), b_addr, 32'h0);
      check($sformatf("b wait%0d en", i), {31'b0, b_en}, 32'd0);
      check($sformatf("b wait%0d cnt", i), {30'b0, b_cnt}, (i < 3) ? i : 3);
    end
    @(negedge clk); ack = 1'b1; #1;
    check("b sat cnt", {30'b0, b_cnt}, 32'd3);
    check("b resume pc_out", b_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
